// File: rtl/tlb_cp0_pkg.sv
// Shared register numbers, field widths and the TLB write-port word layout for the CP0 TLB slice.
// Pure declarations: no latency, no flow control.
package tlb_cp0_pkg;

    localparam logic [4:0] CP0_INDEX    = 5'd0;
    localparam logic [4:0] CP0_RANDOM   = 5'd1;
    localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
    localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
    localparam logic [4:0] CP0_CONTEXT  = 5'd4;
    localparam logic [4:0] CP0_WIRED    = 5'd6;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

    localparam int TLB_IDX_W = 4;
    localparam int VPN2_W    = 19;
    localparam int PFN_W     = 24;

    typedef struct packed {
        logic [VPN2_W-1:0]    vpn2;
        logic [PFN_W-1:0]     pfn1;
        logic                 d1;
        logic                 v1;
        logic [PFN_W-1:0]     pfn0;
        logic                 d0;
        logic                 v0;
        logic [TLB_IDX_W-1:0] idx;
    } tlb_cfg_t;

endpackage

// File: rtl/tlb_random_ctr.sv
// Random down-counter with Wired floor; a Wired write reloads Random to the top entry on the same edge.
// Updates every cycle, no backpressure.
module tlb_random_ctr
    import tlb_cp0_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wiredWe,
    input  logic [TLB_IDX_W-1:0] wiredWdata,
    output logic [TLB_IDX_W-1:0] random,
    output logic [TLB_IDX_W-1:0] wired
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            random <= '1;
            wired  <= '0;
        end else if (wiredWe) begin
            wired  <= wiredWdata;
            random <= '1;
        end else if (random == wired) begin
            // Wired == 15 lands here every cycle, so Random parks at 15.
            random <= '1;
        end else begin
            random <= random - TLB_IDX_W'(1);
        end
    end

endmodule

// File: rtl/tlb_cp0_regs.sv
// CP0 TLB register slice: MTC0/MFC0 access, exception capture, 75-bit TLB write word with 1-cycle strobe.
// Config and strobe follow the request by one cycle, no backpressure; TLB_RANDOM_EN adds Random/Wired for TLBWR.
module tlb_cp0_regs
    import tlb_cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic        tlbwi_req,
    input  logic        tlbwr_req,
    input  logic        exc_tlb,
    input  logic [31:0] exc_vaddr,
    output logic [74:0] tlbConfig,
    output logic        tlbwi
);

    logic                 indexP;
    logic [TLB_IDX_W-1:0] indexIdx;
    logic [29:0]          entryLo0;
    logic [29:0]          entryLo1;
    logic [8:0]           pteBase;
    logic [VPN2_W-1:0]    badVpn2;
    logic [VPN2_W-1:0]    vpn2;
    logic [7:0]           asid;
    logic [31:0]          badVAddr;
    tlb_cfg_t             cfgQ;
    logic                 tlbwiQ;

    logic [TLB_IDX_W-1:0] randomVal;
    logic [TLB_IDX_W-1:0] wiredVal;
    logic [TLB_IDX_W-1:0] reqIdx;
    logic                 tlbReq;

    assign tlbReq = tlbwi_req | tlbwr_req;

`ifdef TLB_RANDOM_EN
    tlb_random_ctr u_randomCtr (
        .clk        (clk),
        .rst_n      (rst_n),
        .wiredWe    (cp0_we && (cp0_waddr == CP0_WIRED)),
        .wiredWdata (cp0_wdata[TLB_IDX_W-1:0]),
        .random     (randomVal),
        .wired      (wiredVal)
    );
    assign reqIdx = tlbwi_req ? indexIdx : randomVal;
`else
    assign randomVal = '0;
    assign wiredVal  = '0;
    assign reqIdx    = indexIdx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            indexP   <= 1'b0;
            indexIdx <= '0;
            entryLo0 <= '0;
            entryLo1 <= '0;
            pteBase  <= '0;
            badVpn2  <= '0;
            vpn2     <= '0;
            asid     <= '0;
            badVAddr <= '0;
        end else begin
            if (cp0_we) begin
                case (cp0_waddr)
                    CP0_INDEX: begin
                        indexP   <= cp0_wdata[31];
                        indexIdx <= cp0_wdata[TLB_IDX_W-1:0];
                    end
                    CP0_ENTRYLO0: entryLo0 <= cp0_wdata[29:0];
                    CP0_ENTRYLO1: entryLo1 <= cp0_wdata[29:0];
                    CP0_CONTEXT:  pteBase  <= cp0_wdata[31:23];
                    CP0_ENTRYHI: begin
                        vpn2 <= cp0_wdata[31:13];
                        asid <= cp0_wdata[7:0];
                    end
                    default: ;
                endcase
            end
            // Placed after the MTC0 decode so a same-cycle miss overrides the written VPN2.
            if (exc_tlb) begin
                badVAddr <= exc_vaddr;
                vpn2     <= exc_vaddr[31:13];
                badVpn2  <= exc_vaddr[31:13];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfgQ   <= '0;
            tlbwiQ <= 1'b0;
        end else begin
            tlbwiQ <= tlbReq;
            if (tlbReq) begin
                cfgQ.vpn2 <= vpn2;
                cfgQ.pfn1 <= entryLo1[29:6];
                cfgQ.d1   <= entryLo1[2];
                cfgQ.v1   <= entryLo1[1];
                cfgQ.pfn0 <= entryLo0[29:6];
                cfgQ.d0   <= entryLo0[2];
                cfgQ.v0   <= entryLo0[1];
                cfgQ.idx  <= reqIdx;
            end
        end
    end

    assign tlbConfig = cfgQ;
    assign tlbwi     = tlbwiQ;

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_INDEX:    cp0_rdata = {indexP, 27'b0, indexIdx};
            CP0_RANDOM:   cp0_rdata = {28'b0, randomVal};
            CP0_ENTRYLO0: cp0_rdata = {2'b0, entryLo0};
            CP0_ENTRYLO1: cp0_rdata = {2'b0, entryLo1};
            CP0_CONTEXT:  cp0_rdata = {pteBase, badVpn2, 4'b0};
            CP0_WIRED:    cp0_rdata = {28'b0, wiredVal};
            CP0_BADVADDR: cp0_rdata = badVAddr;
            CP0_ENTRYHI:  cp0_rdata = {vpn2, 5'b0, asid};
            default:      cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_tlb_cp0_regs.sv
// Directed bench for tlb_cp0_regs with an expected-value queue; covers both TLB_RANDOM_EN builds.
module tb_tlb_cp0_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        tlbwi_req;
    logic        tlbwr_req;
    logic        exc_tlb;
    logic [31:0] exc_vaddr;
    logic [74:0] tlbConfig;
    logic        tlbwi;

    int errors = 0;
    int checks = 0;

    logic [74:0] expQ[$];
    string       tagQ[$];

    always #5 clk = ~clk;

    tlb_cp0_regs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cp0_we    (cp0_we),
        .cp0_waddr (cp0_waddr),
        .cp0_wdata (cp0_wdata),
        .cp0_raddr (cp0_raddr),
        .cp0_rdata (cp0_rdata),
        .tlbwi_req (tlbwi_req),
        .tlbwr_req (tlbwr_req),
        .exc_tlb   (exc_tlb),
        .exc_vaddr (exc_vaddr),
        .tlbConfig (tlbConfig),
        .tlbwi     (tlbwi)
    );

    function automatic logic [74:0] mkCfg(input logic [18:0] v2, input logic [23:0] p1,
                                          input logic dd1, input logic vv1, input logic [23:0] p0,
                                          input logic dd0, input logic vv0, input logic [3:0] ix);
        return {v2, p1, dd1, vv1, p0, dd0, vv0, ix};
    endfunction

    task automatic expect_(input string tag, input logic [74:0] v);
        expQ.push_back(v);
        tagQ.push_back(tag);
    endtask

    task automatic check(input logic [74:0] obs);
        logic [74:0] e;
        string t;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_underflow observed=%h", obs);
            return;
        end
        e = expQ.pop_front();
        t = tagQ.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we    = 1'b1;
        cp0_waddr = a;
        cp0_wdata = d;
        step();
        cp0_we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] e);
        cp0_raddr = a;
        expect_(tag, {43'b0, e});
        #1;
        check({43'b0, cp0_rdata});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rndReset;
        logic [3:0] wrIdx;
`ifdef TLB_RANDOM_EN
        rndReset = 4'd15;
        wrIdx    = 4'd9;
`else
        rndReset = 4'd0;
        wrIdx    = 4'd5;
`endif
        rst_n = 1'b0; cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0; cp0_raddr = '0;
        tlbwi_req = 1'b0; tlbwr_req = 1'b0; exc_tlb = 1'b0; exc_vaddr = '0;
        step();
        step();

        expect_("reset_tlbwi", 75'd0);
        check({74'b0, tlbwi});
        expect_("reset_tlbConfig", 75'd0);
        check(tlbConfig);
        rd("reset_index", 5'd0, 32'h0);
        rd("reset_entryhi", 5'd10, 32'h0);
        rst_n = 1'b1;
        rd("reset_random", 5'd1, {28'b0, rndReset});

`ifdef TLB_RANDOM_EN
        for (int i = 1; i <= 16; i++) begin
            step();
            rd("random_seq", 5'd1, (i < 16) ? 32'(15 - i) : 32'd15);
        end
        mtc0(5'd6, 32'd4);
        rd("wired_read", 5'd6, 32'd4);
        rd("random_after_wired", 5'd1, 32'd15);
        for (int i = 1; i <= 12; i++) begin
            step();
            rd("random_wired4", 5'd1, (i < 12) ? 32'(15 - i) : 32'd15);
        end
`else
        mtc0(5'd6, 32'd4);
        rd("wired_absent", 5'd6, 32'd0);
        rd("random_absent", 5'd1, 32'd0);
`endif

        // Register load and TLBWI
        mtc0(5'd0, 32'h80000005);
        mtc0(5'd10, 32'h123460A5);
        mtc0(5'd2, 32'h00000046);
        mtc0(5'd3, 32'h00000087);
        rd("index_p", 5'd0, 32'h80000005);
        rd("entryhi_rd", 5'd10, 32'h123460A5);
        rd("entrylo0_rd", 5'd2, 32'h00000046);
        rd("entrylo1_rd", 5'd3, 32'h00000087);
        tlbwi_req = 1'b1;
        expect_("tlbwi_strobe", 75'd1);
        expect_("tlbwi_config", mkCfg(19'h091A3, 24'h2, 1'b1, 1'b1, 24'h1, 1'b1, 1'b1, 4'd5));
        step();
        tlbwi_req = 1'b0;
        check({74'b0, tlbwi});
        check(tlbConfig);
        expect_("tlbwi_one_cycle", 75'd0);
        expect_("tlbConfig_hold", mkCfg(19'h091A3, 24'h2, 1'b1, 1'b1, 24'h1, 1'b1, 1'b1, 4'd5));
        step();
        check({74'b0, tlbwi});
        check(tlbConfig);

        // TLBWR: Random index when present, Index otherwise
`ifdef TLB_RANDOM_EN
        mtc0(5'd6, 32'd0);
        for (int i = 0; i < 6; i++) step();
        rd("random_at_9", 5'd1, 32'd9);
`endif
        tlbwr_req = 1'b1;
        expect_("tlbwr_strobe", 75'd1);
        expect_("tlbwr_config", mkCfg(19'h091A3, 24'h2, 1'b1, 1'b1, 24'h1, 1'b1, 1'b1, wrIdx));
        step();
        tlbwr_req = 1'b0;
        check({74'b0, tlbwi});
        check(tlbConfig);

        // Field masking and read-only/unmapped registers
        mtc0(5'd4, 32'hFFFFFFFF);
        rd("context_mask", 5'd4, 32'hFF800000);
        mtc0(5'd8, 32'h12345678);
        rd("badvaddr_ro", 5'd8, 32'h0);
        mtc0(5'd5, 32'hFFFFFFFF);
        rd("unmapped", 5'd5, 32'h0);
        mtc0(5'd2, 32'hFFFFFFFF);
        rd("entrylo0_mask", 5'd2, 32'h3FFFFFFF);
        mtc0(5'd10, 32'hFFFFFFFF);
        rd("entryhi_mask", 5'd10, 32'hFFFFE0FF);
        mtc0(5'd10, 32'h123460A5);

        // TLB exception capture
        exc_tlb = 1'b1;
        exc_vaddr = 32'hDEADB000;
        step();
        exc_tlb = 1'b0;
        rd("exc_badvaddr", 5'd8, 32'hDEADB000);
        rd("exc_entryhi", 5'd10, 32'hDEADA0A5);
        rd("exc_context", 5'd4, {9'h1FF, 19'h6F56D, 4'h0});

        // Exception + MTC0 EntryHi + TLBWI together
        cp0_we = 1'b1; cp0_waddr = 5'd10; cp0_wdata = 32'hFFFFE033;
        exc_tlb = 1'b1; exc_vaddr = 32'h00002000;
        tlbwi_req = 1'b1;
        expect_("combo_strobe", 75'd1);
        expect_("combo_config", mkCfg(19'h6F56D, 24'h2, 1'b1, 1'b1, 24'hFFFFFF, 1'b1, 1'b1, 4'd5));
        step();
        cp0_we = 1'b0; exc_tlb = 1'b0; tlbwi_req = 1'b0;
        check({74'b0, tlbwi});
        check(tlbConfig);
        rd("combo_entryhi", 5'd10, 32'h00002033);
        rd("combo_badvaddr", 5'd8, 32'h00002000);

        // TLBWI+TLBWR with same-cycle Index write uses old Index
        mtc0(5'd0, 32'd2);
        cp0_we = 1'b1; cp0_waddr = 5'd0; cp0_wdata = 32'd7;
        tlbwi_req = 1'b1; tlbwr_req = 1'b1;
        expect_("both_req_idx", 75'd2);
        step();
        cp0_we = 1'b0; tlbwi_req = 1'b0; tlbwr_req = 1'b0;
        check({71'b0, tlbConfig[3:0]});
        rd("index_after", 5'd0, 32'd7);

        // Back-to-back requests
        tlbwi_req = 1'b1;
        cp0_we = 1'b1; cp0_waddr = 5'd0; cp0_wdata = 32'd3;
        expect_("b2b_strobe0", 75'd1);
        expect_("b2b_idx0", 75'd7);
        step();
        cp0_we = 1'b0;
        check({74'b0, tlbwi});
        check({71'b0, tlbConfig[3:0]});
        expect_("b2b_strobe1", 75'd1);
        expect_("b2b_idx1", 75'd3);
        step();
        tlbwi_req = 1'b0;
        check({74'b0, tlbwi});
        check({71'b0, tlbConfig[3:0]});
        expect_("b2b_idle", 75'd0);
        step();
        check({74'b0, tlbwi});

        // Asynchronous reset kills a pending strobe
        tlbwi_req = 1'b1;
        expect_("pre_reset_strobe", 75'd1);
        step();
        tlbwi_req = 1'b0;
        check({74'b0, tlbwi});
        #2;
        rst_n = 1'b0;
        #1;
        expect_("async_reset_tlbwi", 75'd0);
        check({74'b0, tlbwi});
        expect_("async_reset_cfg", 75'd0);
        check(tlbConfig);
        rd("async_reset_index", 5'd0, 32'h0);
        rd("async_reset_random", 5'd1, {28'b0, rndReset});
        step();
        rst_n = 1'b1;
        step();
        expect_("post_reset_tlbwi", 75'd0);
        check({74'b0, tlbwi});

        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover count=%0d", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
